// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side bus bundle for the memory port arbiter.
// slave = arbiter view, master = pipeline/RAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: data-priority with fetch starvation guard,
// two-stage read-return pipeline routing data back to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [15:0] conflict_cnt
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic [15:0]       conf_q, conf_d;
  logic              s1_v_q, s1_v_d;
  logic              s1_own_q, s1_own_d;
  logic              if_rv_q, d_rv_q;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;
  logic              force_if;
  logic              d_gnt, if_gnt;
  logic              if_ret, d_ret;

  // Grant decision and RAM drive; the winner owns the RAM this cycle.
  always_comb begin
    force_if      = (starve_q == SMAX);
    d_gnt         = bus.d_req & ~(force_if & bus.if_req);
    if_gnt        = bus.if_req & ~d_gnt;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (d_gnt) begin
      bus.ram_addr  = bus.d_addr;
      bus.ram_we    = bus.d_we;
      bus.ram_wdata = bus.d_wdata;
    end else if (if_gnt) begin
      bus.ram_addr  = bus.if_addr;
    end
  end

  // Next-state for starvation guard, conflict counter and read pipeline.
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt)
      starve_d = '0;
    else if (starve_q != SMAX)
      starve_d = starve_q + 4'd1;

    conf_d = conf_q;
    if (bus.if_req && bus.d_req && conf_q != 16'hFFFF)
      conf_d = conf_q + 16'd1;

    s1_v_d   = if_gnt | (d_gnt & ~bus.d_we);
    s1_own_d = d_gnt;

    if_ret  = s1_v_q & ~s1_own_q;
    d_ret   = s1_v_q & s1_own_q;
    if_rd_d = if_ret ? bus.ram_rdata : if_rd_q;
    d_rd_d  = d_ret ? bus.ram_rdata : d_rd_q;
  end

  // State registers; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      conf_q   <= '0;
      s1_v_q   <= 1'b0;
      s1_own_q <= 1'b0;
      if_rv_q  <= 1'b0;
      d_rv_q   <= 1'b0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
    end else begin
      starve_q <= starve_d;
      conf_q   <= conf_d;
      s1_v_q   <= s1_v_d;
      s1_own_q <= s1_own_d;
      if_rv_q  <= if_ret;
      d_rv_q   <= d_ret;
      if_rd_q  <= if_rd_d;
      d_rd_q   <= d_rd_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rv_q;
  assign bus.d_rvalid  = d_rv_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.d_rdata   = d_rd_q;
  assign conflict_cnt  = conf_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural
// synchronous RAM (registered read, one-cycle latency).
module tb_mem_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic        clk;
  logic        rst_n;
  logic [15:0] conflict_cnt;
  logic [DW-1:0] mem [2**AW];

  int total;
  int passed;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    mem[3] = 32'h33333333;
    mem[4] = 32'h44444444;
    mem[5] = 32'hE3A01001;
    bus.if_req  = 0; bus.if_addr = '0;
    bus.d_req   = 0; bus.d_we    = 0;
    bus.d_addr  = '0; bus.d_wdata = '0;
    rst_n = 1;
    #2 rst_n = 0;
    tick(); tick();
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_conflict", 32'(conflict_cnt), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    rst_n = 1;
    tick();

    // fetch read of address 5
    bus.if_req = 1; bus.if_addr = 11'd5;
    #1;
    chk("f_if_gnt", 32'(bus.if_gnt), 1);
    chk("f_d_gnt", 32'(bus.d_gnt), 0);
    chk("f_ram_addr", 32'(bus.ram_addr), 5);
    chk("f_ram_we", 32'(bus.ram_we), 0);
    tick();
    bus.if_req = 0;
    chk("f_rvalid_t1", 32'(bus.if_rvalid), 0);
    tick();
    chk("f_rvalid_t2", 32'(bus.if_rvalid), 1);
    chk("f_rdata_t2", bus.if_rdata, 32'hE3A01001);
    chk("f_d_rvalid", 32'(bus.d_rvalid), 0);
    tick();
    chk("f_rvalid_t3", 32'(bus.if_rvalid), 0);

    // data write then read back of address 10
    bus.d_req = 1; bus.d_we = 1;
    bus.d_addr = 11'd10; bus.d_wdata = 32'hDEADBEEF;
    #1;
    chk("w_d_gnt", 32'(bus.d_gnt), 1);
    chk("w_ram_we", 32'(bus.ram_we), 1);
    chk("w_ram_addr", 32'(bus.ram_addr), 10);
    chk("w_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
    tick();
    bus.d_we = 0; bus.d_wdata = '0;
    #1;
    chk("r_d_gnt", 32'(bus.d_gnt), 1);
    chk("r_ram_we", 32'(bus.ram_we), 0);
    chk("w_no_rvalid1", 32'(bus.d_rvalid), 0);
    tick();
    bus.d_req = 0;
    chk("w_no_rvalid2", 32'(bus.d_rvalid), 0);
    tick();
    chk("r_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("r_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    chk("r_if_rvalid", 32'(bus.if_rvalid), 0);
    tick();
    chk("r_d_rvalid_end", 32'(bus.d_rvalid), 0);

    // continuous contention: 4 data grants, then 1 forced fetch
    bus.if_req = 1; bus.if_addr = 11'd7;
    bus.d_req = 1;  bus.d_addr = 11'd8;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) bus.if_req = 0;
      #1;
      chk($sformatf("c_d_gnt_%0d", i), 32'(bus.d_gnt),
          (i % 5 != 4 || i == 14) ? 1 : 0);
      chk($sformatf("c_if_gnt_%0d", i), 32'(bus.if_gnt),
          (i % 5 == 4 && i != 14) ? 1 : 0);
      chk($sformatf("c_conf_%0d", i), 32'(conflict_cnt), i);
      tick();
    end
    bus.if_req = 1;
    repeat (65540) tick();
    chk("sat_conf", 32'(conflict_cnt), 32'hFFFF);
    tick();
    chk("sat_conf_hold", 32'(conflict_cnt), 32'hFFFF);
    bus.if_req = 0; bus.d_req = 0;
    repeat (3) tick();

    // alternating fetch/data reads, addresses 1..4
    bus.if_req = 1; bus.if_addr = 11'd1;
    #1 chk("a1_if_gnt", 32'(bus.if_gnt), 1);
    tick();
    bus.if_req = 0; bus.d_req = 1; bus.d_addr = 11'd2;
    #1 chk("a2_d_gnt", 32'(bus.d_gnt), 1);
    tick();
    bus.d_req = 0; bus.if_req = 1; bus.if_addr = 11'd3;
    #1;
    chk("a3_if_gnt", 32'(bus.if_gnt), 1);
    chk("a3_if_rvalid", 32'(bus.if_rvalid), 1);
    chk("a3_if_rdata", bus.if_rdata, 32'h11111111);
    chk("a3_d_rvalid", 32'(bus.d_rvalid), 0);
    tick();
    bus.if_req = 0; bus.d_req = 1; bus.d_addr = 11'd4;
    #1;
    chk("a4_d_gnt", 32'(bus.d_gnt), 1);
    chk("a4_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("a4_d_rdata", bus.d_rdata, 32'h22222222);
    chk("a4_if_rvalid", 32'(bus.if_rvalid), 0);
    chk("a4_if_rdata_hold", bus.if_rdata, 32'h11111111);
    tick();
    bus.d_req = 0;
    chk("a5_if_rvalid", 32'(bus.if_rvalid), 1);
    chk("a5_if_rdata", bus.if_rdata, 32'h33333333);
    chk("a5_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("a5_d_rdata_hold", bus.d_rdata, 32'h22222222);
    tick();
    chk("a6_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("a6_d_rdata", bus.d_rdata, 32'h44444444);
    chk("a6_if_rvalid", 32'(bus.if_rvalid), 0);
    tick();
    chk("a7_if_rvalid", 32'(bus.if_rvalid), 0);
    chk("a7_d_rvalid", 32'(bus.d_rvalid), 0);

    // all-ones address read, then reset while it is in flight
    bus.if_req = 1; bus.if_addr = 11'h7FF;
    #1;
    chk("m_if_gnt", 32'(bus.if_gnt), 1);
    chk("m_ram_addr", 32'(bus.ram_addr), 32'h7FF);
    tick();
    bus.if_req = 0;
    #2 rst_n = 0;
    #1;
    chk("mr_if_rvalid", 32'(bus.if_rvalid), 0);
    chk("mr_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("mr_if_rdata", bus.if_rdata, 0);
    chk("mr_d_rdata", bus.d_rdata, 0);
    chk("mr_conflict", 32'(conflict_cnt), 0);
    chk("mr_ram_addr", 32'(bus.ram_addr), 0);
    chk("mr_ram_we", 32'(bus.ram_we), 0);
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_if_rvalid_%0d", i), 32'(bus.if_rvalid), 0);
      chk($sformatf("post_d_rvalid_%0d", i), 32'(bus.d_rvalid), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
